wr_frame_buf: RTL and testbench

- Asymmetric-width simple dual-port line buffer for video writes toward DDR.
- Port A is write-only: 32-bit words, 4096 deep.
- Port B is read-only: 128-bit words, 1024 deep.
- Sits between the pixel packer (24/16/32-bit pixels packed into 32-bit words) and the DDR write burst engine, which reads 128-bit beats.

---
 rtl/wr_frame_buf_pkg.sv | 18 +
 rtl/wr_frame_buf_lane.sv | 42 ++++
 rtl/wr_frame_buf.sv | 53 +++++
 tb/tb_wr_frame_buf.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_frame_buf_pkg.sv
// Shared sizing for the asymmetric video write line buffer.
// The 32-bit write words pack into 128-bit DDR beats.
package wr_frame_buf_pkg;

    localparam int unsigned A_DATA_WIDTH_DEF = 32;
    localparam int unsigned A_ADDR_WIDTH_DEF = 12;
    localparam int unsigned B_DATA_WIDTH_DEF = 128;
    localparam int unsigned B_ADDR_WIDTH_DEF = 10;

    localparam int unsigned RATIO_DEF     = B_DATA_WIDTH_DEF / A_DATA_WIDTH_DEF;
    localparam int unsigned LANE_BITS_DEF = $clog2(RATIO_DEF);

    // Width of the lane index field, given a power-of-two width ratio.
    function automatic int unsigned lane_bits(input int unsigned ratio);
        return $clog2(ratio);
    endfunction

endpackage

// File: rtl/wr_frame_buf_lane.sv
// One write lane of the line buffer: a RAM with a single write port and a
// synchronous, read-first read port. The read register clears on reset.
module wr_frame_buf_lane #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // The array has no reset, so the storage can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_d = mem_q[rd_addr_i];
    end

    // Same-edge write and read sample the old word, so a collision is read-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/wr_frame_buf.sv
// Asymmetric simple dual-port line buffer: 32-bit writes from the pixel
// packer, 128-bit reads by the DDR burst engine. Lower word goes to lower lane.
module wr_frame_buf
    import wr_frame_buf_pkg::*;
#(
    parameter int unsigned A_DATA_WIDTH = A_DATA_WIDTH_DEF,
    parameter int unsigned A_ADDR_WIDTH = A_ADDR_WIDTH_DEF,
    parameter int unsigned B_DATA_WIDTH = B_DATA_WIDTH_DEF,
    parameter int unsigned B_ADDR_WIDTH = B_ADDR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [A_DATA_WIDTH-1:0] a_wr_data,
    input  logic [A_ADDR_WIDTH-1:0] a_addr,
    input  logic                    a_wr_en,
    input  logic [B_ADDR_WIDTH-1:0] b_addr,
    output logic [B_DATA_WIDTH-1:0] b_rd_data
);

    localparam int unsigned RATIO     = B_DATA_WIDTH / A_DATA_WIDTH;
    localparam int unsigned LANE_BITS = lane_bits(RATIO);

    logic [RATIO-1:0]        lane_we;
    logic [B_ADDR_WIDTH-1:0] wr_row;
    logic [LANE_BITS-1:0]    wr_lane;

    assign wr_lane = a_addr[LANE_BITS-1:0];
    assign wr_row  = a_addr[A_ADDR_WIDTH-1:LANE_BITS];

    // Writes are blocked while reset is held, even though the RAM itself is not cleared.
    always_comb begin
        lane_we = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            lane_we[i] = a_wr_en && !rst && (wr_lane == LANE_BITS'(i));
        end
    end

    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        wr_frame_buf_lane #(
            .DATA_WIDTH(A_DATA_WIDTH),
            .ADDR_WIDTH(B_ADDR_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .we_i      (lane_we[k]),
            .wr_addr_i (wr_row),
            .wr_data_i (a_wr_data),
            .rd_addr_i (b_addr),
            .rd_data_o (b_rd_data[k*A_DATA_WIDTH +: A_DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_wr_frame_buf.sv
// Scoreboard bench for wr_frame_buf: a word-level model predicts each 128-bit
// beat when its read is issued, and the beat is compared one edge later.
module tb_wr_frame_buf;

    logic         clk;
    logic         rst;
    logic [31:0]  a_wr_data;
    logic [11:0]  a_addr;
    logic         a_wr_en;
    logic [9:0]   b_addr;
    logic [127:0] b_rd_data;

    logic [31:0]  model [4096];
    logic [127:0] sb_q [$];
    int unsigned  checks;
    int unsigned  errors;

    wr_frame_buf #(
        .A_DATA_WIDTH(32),
        .A_ADDR_WIDTH(12),
        .B_DATA_WIDTH(128),
        .B_ADDR_WIDTH(10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_wr_data (a_wr_data),
        .a_addr    (a_addr),
        .a_wr_en   (a_wr_en),
        .b_addr    (b_addr),
        .b_rd_data (b_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] model_row(input logic [9:0] row);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[k*32 +: 32] = model[{row, 2'(k)}];
        end
        return r;
    endfunction

    // One clock: drive ports, predict the beat (pre-write contents), update the
    // model, then step to 1 time unit after the edge.
    task automatic cycle(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                         input logic [9:0] ra, input bit push);
        a_wr_en   = we;
        a_addr    = wa;
        a_wr_data = wd;
        b_addr    = ra;
        if (push) sb_q.push_back(model_row(ra));
        if (we && !rst) model[wa] = wd;
        @(posedge clk);
        #1;
        a_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [127:0] exp;
        rst = 1'b0;
        a_wr_en = 1'b0; a_addr = '0; a_wr_data = '0; b_addr = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (b_rd_data !== '0) begin
            errors++;
            $display("FAIL reset_initial got %h want 0", b_rd_data);
        end
        repeat (2) @(posedge clk);
        #1;
        exp = '0;
        checks++;
        if (b_rd_data !== exp) begin
            errors++;
            $display("FAIL reset_held got %h want %h", b_rd_data, exp);
        end
        rst = 1'b0;
    endtask

    task automatic test_lane_packing();
        logic [127:0] exp;
        cycle(1'b1, 12'd0, 32'h11111111, 10'd0, 1'b0);
        cycle(1'b1, 12'd1, 32'h22222222, 10'd0, 1'b0);
        cycle(1'b1, 12'd2, 32'h33333333, 10'd0, 1'b0);
        cycle(1'b1, 12'd3, 32'h44444444, 10'd0, 1'b0);
        cycle(1'b0, 12'd0, 32'h0, 10'd0, 1'b1);
        exp = sb_q.pop_front();
        checks++;
        if (b_rd_data !== exp || exp !== 128'h44444444_33333333_22222222_11111111) begin
            errors++;
            $display("FAIL lane_packing got %h want %h", b_rd_data, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] exp;
        logic [127:0] row0;
        row0 = model_row(10'd0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (b_rd_data !== '0) begin
            errors++;
            $display("FAIL async_reset_immediate got %h want 0", b_rd_data);
        end
        @(posedge clk);
        #1;
        // Write attempted under reset must be dropped; model skips it too.
        cycle(1'b1, 12'd1, 32'hBADBAD00, 10'd0, 1'b0);
        checks++;
        if (b_rd_data !== '0) begin
            errors++;
            $display("FAIL async_reset_hold got %h want 0", b_rd_data);
        end
        rst = 1'b0;
        cycle(1'b0, 12'd0, 32'h0, 10'd0, 1'b1);
        exp = sb_q.pop_front();
        checks++;
        if (b_rd_data !== exp || exp !== row0) begin
            errors++;
            $display("FAIL reset_release_read got %h want %h", b_rd_data, exp);
        end
    endtask

    task automatic test_top_boundary();
        logic [127:0] exp;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 12'(4092 + i), 32'(8'hA0 + i), 10'd0, 1'b0);
        end
        cycle(1'b0, 12'd0, 32'h0, 10'd1023, 1'b1);
        exp = sb_q.pop_front();
        checks++;
        if (b_rd_data !== exp || exp !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            errors++;
            $display("FAIL top_boundary got %h want %h", b_rd_data, exp);
        end
        cycle(1'b0, 12'd0, 32'h0, 10'd0, 1'b1);
        exp = sb_q.pop_front();
        checks++;
        if (b_rd_data !== exp) begin
            errors++;
            $display("FAIL row0_unchanged got %h want %h", b_rd_data, exp);
        end
    endtask

    task automatic test_partial_update();
        logic [127:0] exp;
        cycle(1'b1, 12'd2, 32'hDEADBEEF, 10'd1023, 1'b0);
        cycle(1'b0, 12'd0, 32'h0, 10'd0, 1'b1);
        exp = sb_q.pop_front();
        checks++;
        if (b_rd_data !== exp || exp !== 128'h44444444_DEADBEEF_22222222_11111111) begin
            errors++;
            $display("FAIL partial_update got %h want %h", b_rd_data, exp);
        end
    endtask

    task automatic test_read_first();
        logic [127:0] exp;
        logic [127:0] old_row;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 12'(20 + i), 32'h50500000 + 32'(i), 10'd0, 1'b0);
        end
        old_row = 128'h50500003_50500002_50500001_50500000;
        cycle(1'b1, 12'd21, 32'hCAFEF00D, 10'd5, 1'b1);
        exp = sb_q.pop_front();
        checks++;
        if (b_rd_data !== exp || exp !== old_row) begin
            errors++;
            $display("FAIL read_first_old got %h want %h", b_rd_data, exp);
        end
        cycle(1'b0, 12'd0, 32'h0, 10'd5, 1'b1);
        exp = sb_q.pop_front();
        checks++;
        if (b_rd_data !== exp || b_rd_data[63:32] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL read_first_new got %h want %h", b_rd_data, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp;
        int unsigned  bad;
        for (int i = 0; i < 1440; i++) begin
            cycle(1'b1, 12'(i), $urandom, 10'(i % 1024), 1'b0);
        end
        for (int pass = 0; pass < 2; pass++) begin
            bad = 0;
            for (int r = 0; r < 360; r++) begin
                if (pass == 0 && r == 180) begin
                    rst = 1'b1;
                    cycle(1'b0, 12'd0, 32'h0, 10'(r), 1'b0);
                    checks++;
                    if (b_rd_data !== '0) begin
                        errors++;
                        $display("FAIL stream_reset got %h want 0", b_rd_data);
                    end
                    rst = 1'b0;
                end
                cycle(1'b0, 12'd0, 32'h0, 10'(r), 1'b1);
                exp = sb_q.pop_front();
                checks++;
                if (b_rd_data !== exp) begin
                    errors++;
                    bad++;
                    if (bad <= 4) $display("FAIL stream_beat pass %0d row %0d got %h want %h",
                                           pass, r, b_rd_data, exp);
                end
            end
            if (pass == 0) begin
                rst = 1'b1;
                #3 rst = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sb_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4096; i++) model[i] = '0;
        test_reset();
        test_lane_packing();
        test_async_reset();
        test_top_boundary();
        test_partial_update();
        test_read_first();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
